// File: rtl/pmp_cfg_if.sv
// Register-port bundle for the PMP configuration register file.
// Single outstanding req/gnt access with a one-cycle rvalid response.
interface pmp_cfg_if;
    logic        req_i;
    logic        gnt_o;
    logic        we_i;
    logic [4:0]  addr_i;
    logic [63:0] wdata_i;
    logic [7:0]  be_i;
    logic        rvalid_o;
    logic [63:0] rdata_o;
    logic        err_o;

    modport master (
        output req_i, we_i, addr_i, wdata_i, be_i,
        input  gnt_o, rvalid_o, rdata_o, err_o
    );

    modport slave (
        input  req_i, we_i, addr_i, wdata_i, be_i,
        output gnt_o, rvalid_o, rdata_o, err_o
    );
endinterface

// File: rtl/pmp_cfg_regfile.sv
// PMP configuration register file (pmpcfg bytes + pmpaddr) enforcing WARL and lock rules.
// Build macro PMP_CFG_SHADOW_EN adds a shadow copy that a COMMIT write publishes atomically.
module pmp_cfg_regfile #(
    parameter int PMP_LEN    = 54,
    parameter int NR_ENTRIES = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    pmp_cfg_if.slave                 bus,
    output logic [15:0][PMP_LEN-1:0] conf_addr_o,
    output logic [15:0][7:0]         conf_o
);

    typedef logic [15:0][7:0]         cfg_arr_t;
    typedef logic [15:0][PMP_LEN-1:0] addr_arr_t;

    typedef enum logic [1:0] {
        K_CFG    = 2'd0,
        K_ADDR   = 2'd1,
        K_COMMIT = 2'd2,
        K_BAD    = 2'd3
    } kind_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RESP = 1'b1
    } state_t;

    function automatic logic [15:0] entry_mask(input int n);
        logic [15:0] m;
        m = 16'd0;
        for (int i = 0; i < 16; i++) begin
            if (i < n) m[i] = 1'b1;
            else       m[i] = 1'b0;
        end
        return m;
    endfunction

    localparam logic [15:0] ENT_VALID = entry_mask(NR_ENTRIES);

    // Reserved bits cleared; W is only kept when R is set.
    function automatic logic [7:0] legalize_cfg(input logic [7:0] wd);
        return {wd[7], 2'b00, wd[4:3], wd[2], wd[1] & wd[0], wd[0]};
    endfunction

    // pmpaddr[i] is frozen by its own lock or by a locked TOR entry above it.
    function automatic logic addr_locked(input cfg_arr_t cfg, input logic [3:0] idx);
        logic lk;
        lk = cfg[idx][7];
        if (idx != 4'd15) lk = lk | (cfg[idx + 4'd1][7] & (cfg[idx + 4'd1][4:3] == 2'b01));
        else              lk = lk;
        return lk;
    endfunction

    function automatic logic [63:0] zext_addr(input logic [PMP_LEN-1:0] a);
        logic [63:0] r;
        r = 64'd0;
        r[PMP_LEN-1:0] = a;
        return r;
    endfunction

    state_t      state_r;
    logic        gnt_r;
    logic        rvalid_r;
    logic [63:0] rdata_r;
    logic        err_r;

    cfg_arr_t    cfg_r;
    addr_arr_t   addr_r;
    cfg_arr_t    rd_cfg_s;
    addr_arr_t   rd_addr_s;
    cfg_arr_t    wr_cfg_s;
    addr_arr_t   wr_addr_s;

    kind_t       kind_s;
    logic [3:0]  aidx_s;
    logic [3:0]  ent_s;
    logic [63:0] rdata_s;
    logic        err_s;
    logic        gnt_s;
    logic        acc_s;

`ifdef PMP_CFG_SHADOW_EN
    cfg_arr_t    shd_cfg_r;
    addr_arr_t   shd_addr_r;
    cfg_arr_t    commit_cfg_s;
    addr_arr_t   commit_addr_s;
    logic        commit_s;

    assign rd_cfg_s  = shd_cfg_r;
    assign rd_addr_s = shd_addr_r;
    assign commit_s  = (kind_s == K_COMMIT) & bus.we_i;
`else
    assign rd_cfg_s  = cfg_r;
    assign rd_addr_s = addr_r;
`endif

    assign gnt_s        = gnt_r & ~rst_i;
    assign acc_s        = bus.req_i & gnt_s;
    assign bus.gnt_o    = gnt_s;
    assign bus.rvalid_o = rvalid_r;
    assign bus.rdata_o  = rdata_r;
    assign bus.err_o    = err_r;
    assign conf_o       = cfg_r;
    assign conf_addr_o  = addr_r;

    // Classify the register index
    always_comb begin
        kind_s = K_BAD;
        if (bus.addr_i <= 5'd1) begin
            kind_s = K_CFG;
        end else if ((bus.addr_i >= 5'd8) && (bus.addr_i <= 5'd23)) begin
            kind_s = K_ADDR;
        end else if (bus.addr_i == 5'd31) begin
            kind_s = K_COMMIT;
        end else begin
            kind_s = K_BAD;
        end
    end

    // Read mux plus the lock/WARL-filtered image of the written copy
    always_comb begin
        wr_cfg_s  = rd_cfg_s;
        wr_addr_s = rd_addr_s;
        rdata_s   = 64'd0;
        err_s     = 1'b0;
        ent_s     = 4'd0;
        aidx_s    = bus.addr_i[3:0] - 4'd8;
        case (kind_s)
            K_CFG: begin
                for (int k = 0; k < 8; k++) begin
                    ent_s = {bus.addr_i[0], 3'(k)};
                    rdata_s[8*k +: 8] = rd_cfg_s[ent_s];
                    // lock state is always taken from the active copy before this write
                    if (bus.we_i && bus.be_i[k] && ENT_VALID[ent_s] && !cfg_r[ent_s][7]) begin
                        wr_cfg_s[ent_s] = legalize_cfg(bus.wdata_i[8*k +: 8]);
                    end else begin
                        wr_cfg_s[ent_s] = rd_cfg_s[ent_s];
                    end
                end
            end
            K_ADDR: begin
                if (!ENT_VALID[aidx_s]) begin
                    err_s   = 1'b1;
                    rdata_s = 64'd0;
                end else if (bus.we_i && !addr_locked(cfg_r, aidx_s)) begin
                    rdata_s           = zext_addr(rd_addr_s[aidx_s]);
                    wr_addr_s[aidx_s] = bus.wdata_i[PMP_LEN-1:0];
                end else begin
                    rdata_s           = zext_addr(rd_addr_s[aidx_s]);
                    wr_addr_s[aidx_s] = rd_addr_s[aidx_s];
                end
            end
            K_COMMIT: begin
                err_s   = 1'b0;
                rdata_s = 64'd0;
            end
            K_BAD: begin
                err_s   = 1'b1;
                rdata_s = 64'd0;
            end
            default: begin
                err_s   = 1'b1;
                rdata_s = 64'd0;
            end
        endcase
    end

`ifdef PMP_CFG_SHADOW_EN
    // Commit image: entries already locked in the active copy are never overwritten
    always_comb begin
        commit_cfg_s  = shd_cfg_r;
        commit_addr_s = shd_addr_r;
        for (int i = 0; i < 16; i++) begin
            if (cfg_r[i][7]) commit_cfg_s[i] = cfg_r[i];
            else             commit_cfg_s[i] = shd_cfg_r[i];
            if (addr_locked(cfg_r, 4'(i))) commit_addr_s[i] = addr_r[i];
            else                           commit_addr_s[i] = shd_addr_r[i];
        end
    end
`endif

    // Configuration storage, updated on the accept edge
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cfg_r  <= '0;
            addr_r <= '0;
`ifdef PMP_CFG_SHADOW_EN
            shd_cfg_r  <= '0;
            shd_addr_r <= '0;
`endif
        end else if (acc_s) begin
`ifdef PMP_CFG_SHADOW_EN
            shd_cfg_r  <= wr_cfg_s;
            shd_addr_r <= wr_addr_s;
            if (commit_s) begin
                cfg_r  <= commit_cfg_s;
                addr_r <= commit_addr_s;
            end
`else
            cfg_r  <= wr_cfg_s;
            addr_r <= wr_addr_s;
`endif
        end
    end

    // Request/response FSM with registered response outputs
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r  <= ST_IDLE;
            gnt_r    <= 1'b1;
            rvalid_r <= 1'b0;
            rdata_r  <= 64'd0;
            err_r    <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (acc_s) begin
                        state_r  <= ST_RESP;
                        gnt_r    <= 1'b0;
                        rvalid_r <= 1'b1;
                        rdata_r  <= rdata_s;
                        err_r    <= err_s;
                    end else begin
                        state_r  <= ST_IDLE;
                        gnt_r    <= 1'b1;
                        rvalid_r <= 1'b0;
                        rdata_r  <= 64'd0;
                        err_r    <= 1'b0;
                    end
                end
                ST_RESP: begin
                    state_r  <= ST_IDLE;
                    gnt_r    <= 1'b1;
                    rvalid_r <= 1'b0;
                    rdata_r  <= 64'd0;
                    err_r    <= 1'b0;
                end
                default: begin
                    state_r  <= ST_IDLE;
                    gnt_r    <= 1'b1;
                    rvalid_r <= 1'b0;
                    rdata_r  <= 64'd0;
                    err_r    <= 1'b0;
                end
            endcase
        end
    end

endmodule
